bcd4_run_counter: RTL and testbench
===================================

# bcd4_run_counter

Four-digit BCD run/stop counter feeding the seven-segment scan multiplexer. It holds a 0000–9999 value that counts up or down once per timebase tick while running, and presents the four digits as nibbles. It also generates the free-running 2-bit scan select that the multiplexer uses to pick the active digit and anode. Control pulses come from the board's debounce/one-pulse stage.

## Interface
- `TICK_MAX`, default 49_999_999: the tick divider counts 0..TICK_MAX. One count update happens every TICK_MAX+1 clocks (1 Hz at 100 MHz).
- `SCAN_BIT`, default 17: MSB index of the scan counter. `sel` = `scan_cnt[SCAN_BIT:SCAN_BIT-1]`. Minimum value is 1.
- `clk`, input, 1: system clock. Single clock domain.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `start_stop_p`, input, 1: single-cycle pulse that toggles between STOP and RUN.
- `clear_p`, input, 1: single-cycle pulse that loads 0000 and forces STOP.
- `dir`, input, 1: level signal. 1 = count up, 0 = count down. Sampled at each tick.
- `q0`, output, 4: ones digit, BCD. This is the rightmost display digit.
- `q1`, output, 4: tens digit, BCD.
- `q2`, output, 4: hundreds digit, BCD.
- `q3`, output, 4: thousands digit, BCD.
- `sel`, output, 2: scan select for the multiplexer.
- `running`, output, 1: 1 while the state is RUN.
- `at_limit`, output, 1: combinational. 1 when (`dir`=1 and value=9999) or (`dir`=0 and value=0000).

## Operation
- **States:** STOP and RUN. `running` = (state==RUN).
- **STOP → RUN:** on `start_stop_p`=1, unless `at_limit`=1. In that case the pulse is ignored and the state stays STOP.
- **RUN → STOP:** on `start_stop_p`=1, or on the tick that produces the limit value (see the count rule below).
- **Clear:** `clear_p`=1 in any state sets all digits to 0, the state to STOP and `tick_cnt` to 0. If `clear_p` and `start_stop_p` arrive on the same clock, `clear_p` wins.
- **Tick divider:**
  - `tick_cnt` holds at 0 in STOP.
  - In RUN it increments each clock. At TICK_MAX it wraps to 0 and the count updates on that edge.
  - It is zeroed on every STOP→RUN transition.
- **Count rule, up:** q0 increments. At 9 it rolls to 0 and carries into q1, and so on through q3.
- **Count rule, down:** q0 decrements. At 0 it rolls to 9 and borrows from q1, and so on through q3.
- **Limit stop:** if the updated value is 9999 (up) or 0000 (down), the state drops to STOP on the same edge. The value never wraps past 9999 or below 0000.
- **Invalid digits:** digits never hold 10–15. A ones digit at 9 with every higher digit at 9, counting up, is the limit case, not a wrap.
- **Direction change:** a `dir` change mid-run takes effect at the next tick. The tick phase is unchanged.
- **Scan counter:** `scan_cnt` is a (SCAN_BIT+1)-bit counter that increments every clock and wraps naturally. It is independent of state, clear and the count.
  - `sel` cycles 0,1,2,3,0,… with each value held for 2^(SCAN_BIT-1) clocks.

## Timing
- **Reset (`rst_n`=0, asynchronous):** q0..q3 = 0, state = STOP, `running`=0, `tick_cnt`=0, `scan_cnt`=0, `sel`=0. `at_limit` = 1 if `dir`=0, else 0.
- **Start latency:** `start_stop_p` sampled at edge E gives `running`=1 after E. The first count update occurs at edge E+TICK_MAX+1, and subsequent updates every TICK_MAX+1 edges.
- **Stop latency:** `start_stop_p` at edge E gives `running`=0 after E and the value freezes. A tick coinciding with E does not update.
- **Clear latency:** `clear_p` at edge E gives digits = 0 and `running`=0 after E. A coinciding tick is discarded.
- **Output registration:** all digit outputs, `running` and `sel` are registered. `at_limit` is combinational from the registered digits and `dir`.
- **Reset mid-run:** asynchronous return to the reset values. Counting resumes only after a new `start_stop_p` following deassertion.

## Test plan
All scenarios use TICK_MAX=3 and SCAN_BIT=1.
1. **Reset and scan:** hold `rst_n` low, then release. Required: all outputs = reset values; `sel` steps 0,1,2,3,0 holding each value for 1 clock.
2. **Up count with carry:** `dir`=1, start pulse at edge E. Required: q=0001 at E+4, 0002 at E+8; after 10 ticks q=0010; after 1000 ticks q3..q0 = 1,0,0,0.
3. **Up limit:** count up from 9998. Required: the next tick gives 9999, `running`=0 and `at_limit`=1; a further start pulse is ignored and the value stays 9999.
4. **Down count and limit:** start from 1000 with `dir`=0. Required: one tick gives 0999; counting on to 0000 sets `running`=0 on that edge; no wrap to 9999.
5. **Pause and resume:** run, then stop pulse two clocks after a tick, then resume at edge F. Required: the value is frozen while stopped; the next update is at F+4.
6. **Priority and mid-run events:** `clear_p` and `start_stop_p` in the same clock. Required: 0000 and STOP. `dir` flipped mid-run: the next tick counts in the new direction with unchanged phase. `rst_n` asserted mid-run: immediate reset values.

Source files
------------

// File: rtl/bcd4_run_counter_if.sv
// bcd4_run_counter_if: control pulses and display outputs of the BCD run counter
interface bcd4_run_counter_if;
  logic start_stop_p, clear_p, dir;
  logic [3:0] q0, q1, q2, q3;
  logic [1:0] sel;
  logic running, at_limit;
  modport master(output start_stop_p, clear_p, dir, input q0, q1, q2, q3, sel, running, at_limit);
  modport slave(input start_stop_p, clear_p, dir, output q0, q1, q2, q3, sel, running, at_limit);
endinterface

// File: rtl/bcd4_run_counter.sv
// bcd4_run_counter: four-digit BCD up/down run counter with display scan select
module bcd4_run_counter #(
  parameter int TICK_MAX = 49_999_999,
  parameter int SCAN_BIT = 17
) (
  input logic clk,
  input logic rst_n,
  bcd4_run_counter_if.slave bus
);
  localparam int TW = TICK_MAX > 0 ? $clog2(TICK_MAX + 1) : 1;
  localparam int SW = SCAN_BIT + 1;
  typedef enum logic {STOP, RUN} state_t;
  state_t state, state_nx;
  logic [TW-1:0] tick_cnt, tick_nx;
  logic [SW-1:0] scan_cnt;
  logic [15:0] val, val_nx, up, dn;
  logic [3:0] c9, c0;
  logic tick, hit;
  assign c9[0] = 1'b1;
  assign c0[0] = 1'b1;
  // c9/c0: every lower digit is 9 (carry) or 0 (borrow)
  for (genvar i = 0; i < 4; i++) begin : g_dig
    if (i < 3) begin : g_chain
      assign c9[i+1] = c9[i] & (val[4*i+:4] == 4'd9);
      assign c0[i+1] = c0[i] & (val[4*i+:4] == 4'd0);
    end
    assign up[4*i+:4] = !c9[i] ? val[4*i+:4] : val[4*i+:4] == 4'd9 ? 4'd0 : val[4*i+:4] + 4'd1;
    assign dn[4*i+:4] = !c0[i] ? val[4*i+:4] : val[4*i+:4] == 4'd0 ? 4'd9 : val[4*i+:4] - 4'd1;
  end
  assign bus.at_limit = bus.dir ? val == 16'h9999 : val == 16'h0000;
  assign tick = tick_cnt == TW'(TICK_MAX);
  assign hit = bus.dir ? up == 16'h9999 : dn == 16'h0000;
  always_comb begin
    state_nx = state;
    tick_nx = '0;
    val_nx = val;
    if (bus.clear_p) begin
      state_nx = STOP;
      val_nx = '0;
    end else if (state == STOP) begin
      state_nx = bus.start_stop_p && !bus.at_limit ? RUN : STOP;
    end else if (bus.start_stop_p) begin
      state_nx = STOP;
    end else if (tick) begin
      val_nx = bus.at_limit ? val : bus.dir ? up : dn;
      state_nx = bus.at_limit || hit ? STOP : RUN;
    end else begin
      tick_nx = tick_cnt + TW'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= STOP;
      tick_cnt <= '0;
      val <= '0;
      scan_cnt <= '0;
    end else begin
      state <= state_nx;
      tick_cnt <= tick_nx;
      val <= val_nx;
      scan_cnt <= scan_cnt + SW'(1);
    end
  assign bus.q0 = val[3:0];
  assign bus.q1 = val[7:4];
  assign bus.q2 = val[11:8];
  assign bus.q3 = val[15:12];
  assign bus.running = state == RUN;
  assign bus.sel = scan_cnt[SCAN_BIT:SCAN_BIT-1];
endmodule

// File: tb/tb_bcd4_run_counter.sv
// tb_bcd4_run_counter: decimal reference model plus directed scenarios for the BCD run counter
module tb_bcd4_run_counter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bcd4_run_counter_if bus();
  bcd4_run_counter #(.TICK_MAX(3), .SCAN_BIT(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  int total = 0, bad = 0, m_val = 0, m_ph = 0, m_scan = 0;
  bit m_run = 1'b0, go = 1'b0;
  function automatic bit lim(int v, logic d);
    return d ? v == 9999 : v == 0;
  endfunction
  function automatic logic [15:0] bcd(int v);
    return {4'(v / 1000), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction
  function automatic logic [15:0] q();
    return {bus.q3, bus.q2, bus.q1, bus.q0};
  endfunction
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", n, a, e, $time);
    end
  endtask
  // decimal model: value as an integer, phase as clocks since start modulo 4
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_val = 0; m_run = 0; m_ph = 0; m_scan = 0;
    end else begin
      m_scan = (m_scan + 1) % 4;
      if (bus.clear_p) begin
        m_val = 0; m_run = 0; m_ph = 0;
      end else if (bus.start_stop_p) begin
        m_run = !m_run && !lim(m_val, bus.dir);
        m_ph = 0;
      end else if (m_run) begin
        m_ph = (m_ph + 1) % 4;
        if (m_ph == 0) begin
          if (!lim(m_val, bus.dir)) m_val += bus.dir ? 1 : -1;
          if (lim(m_val, bus.dir)) m_run = 0;
        end
      end
    end
  end
  always @(negedge clk) if (go) begin
    chk("m_q", q(), bcd(m_val));
    chk("m_running", bus.running, m_run);
    chk("m_sel", bus.sel, m_scan);
    chk("m_at_limit", bus.at_limit, lim(m_val, bus.dir));
  end
  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic pulse(logic c, logic s);
    bus.clear_p = c;
    bus.start_stop_p = s;
    step();
    bus.clear_p = 1'b0;
    bus.start_stop_p = 1'b0;
  endtask
  initial begin
    bus.start_stop_p = 1'b0;
    bus.clear_p = 1'b0;
    bus.dir = 1'b1;
    step(2);
    go = 1'b1;
    step();
    chk("rst_q", q(), 16'h0000);
    chk("rst_running", bus.running, 0);
    chk("rst_sel", bus.sel, 0);
    chk("rst_lim_up", bus.at_limit, 0);
    bus.dir = 1'b0;
    #1 chk("rst_lim_dn", bus.at_limit, 1);
    bus.dir = 1'b1;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("sel_seq", bus.sel, k % 4);
    end
    step();
    pulse(0, 1);
    chk("start_running", bus.running, 1);
    step(3);
    chk("up_e3", q(), 16'h0000);
    step();
    chk("up_e4", q(), 16'h0001);
    step(4);
    chk("up_e8", q(), 16'h0002);
    step(32);
    chk("up_carry10", q(), 16'h0010);
    step(3960);
    chk("up_carry1000", q(), 16'h1000);
    step();
    pulse(0, 1);
    chk("pause_running", bus.running, 0);
    step(10);
    chk("pause_frozen", q(), 16'h1000);
    bus.dir = 1'b0;
    pulse(0, 1);
    chk("resume_running", bus.running, 1);
    step(3);
    chk("resume_f3", q(), 16'h1000);
    step();
    chk("down_f4", q(), 16'h0999);
    step(4 * 998);
    chk("down_0001", q(), 16'h0001);
    step(4);
    chk("down_0000", q(), 16'h0000);
    chk("down_stop", bus.running, 0);
    chk("down_lim", bus.at_limit, 1);
    step(8);
    chk("down_nowrap", q(), 16'h0000);
    bus.dir = 1'b1;
    pulse(0, 1);
    step(6);
    chk("pre_clear", q(), 16'h0001);
    pulse(1, 1);
    chk("clear_q", q(), 16'h0000);
    chk("clear_running", bus.running, 0);
    step(2);
    pulse(0, 1);
    step(8);
    chk("flip_f8", q(), 16'h0002);
    step();
    bus.dir = 1'b0;
    step(2);
    chk("flip_f11", q(), 16'h0002);
    step();
    chk("flip_f12", q(), 16'h0001);
    step();
    bus.dir = 1'b1;
    step(3);
    chk("flip_f16", q(), 16'h0002);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_q", q(), 16'h0000);
    chk("arst_running", bus.running, 0);
    chk("arst_sel", bus.sel, 0);
    step();
    rst_n = 1'b1;
    step(8);
    chk("arst_idle_q", q(), 16'h0000);
    chk("arst_idle_running", bus.running, 0);
    pulse(0, 1);
    step(4 * 9998);
    chk("up_9998", q(), 16'h9998);
    chk("up_9998_running", bus.running, 1);
    step(4);
    chk("up_9999", q(), 16'h9999);
    chk("up_lim_stop", bus.running, 0);
    chk("up_lim", bus.at_limit, 1);
    pulse(0, 1);
    chk("lim_start_ignored", bus.running, 0);
    step(8);
    chk("up_nowrap", q(), 16'h9999);
    bus.dir = 1'b0;
    #1 chk("lim_dn_at_9999", bus.at_limit, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
